// File: rtl/nrisc_pkg.sv
// Shared definitions for the dual-core shared data memory arbiter.
// Holds the arbiter state encoding and the default word/region widths.
package nrisc_pkg;

  localparam int TamDefault      = 16;
  localparam int LDataMemDefault = 8;
  localparam int CntWDefault     = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/shared_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// core that did not own the previous transaction.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic grant
);

  always_comb begin
    grant = 1'b0;
    if (req0 && req1) begin
      grant = ~last_owner;
    end else if (req1) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Arbitrates two cores' accesses to the shared single-port RAM region,
// stalling the waiting core and counting contention cycles.
module shared_mem_arbiter
  import nrisc_pkg::*;
#(
  parameter int TAM      = TamDefault,
  parameter int LDataMem = LDataMemDefault,
  parameter int CntW     = CntWDefault
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [TAM-1:0]      cpu0_addr,
  input  logic [TAM-1:0]      cpu0_wdata,
  input  logic                cpu0_load,
  input  logic                cpu0_write,
  output logic [TAM-1:0]      cpu0_rdata,
  output logic                cpu0_stall,
  input  logic [TAM-1:0]      cpu1_addr,
  input  logic [TAM-1:0]      cpu1_wdata,
  input  logic                cpu1_load,
  input  logic                cpu1_write,
  output logic [TAM-1:0]      cpu1_rdata,
  output logic                cpu1_stall,
  output logic [LDataMem-1:0] mem_addr,
  output logic [TAM-1:0]      mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
  input  logic [TAM-1:0]      mem_rdata,
  output logic [CntW-1:0]     conflict_cnt,
  output state_t              dbg_state
);

  // Handshake: a core holds load/write (level) while its stall is high;
  // the access completes in the cycle stall falls, and read data is valid then.

  state_t              state, state_n;
  logic                owner, owner_n;
  logic                last_owner;
  logic                load_op;
  logic                pick;
  logic                req0, req1;
  logic                conflict;
  logic [LDataMem-1:0] op_addr;
  logic [TAM-1:0]      op_wdata;
  logic                op_write;
  logic [TAM-1:0]      rdata0_q, rdata1_q;
  logic                unused_addr_bits;

  assign req0 = (cpu0_load | cpu0_write) & cpu0_addr[LDataMem];
  assign req1 = (cpu1_load | cpu1_write) & cpu1_addr[LDataMem];
  assign unused_addr_bits = ^{cpu0_addr[TAM-1:LDataMem+1], cpu1_addr[TAM-1:LDataMem+1]};

  rr_arb2 u_rr_arb2 (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner),
    .grant      (pick)
  );

  always_comb begin
    state_n = state;
    owner_n = owner;
    load_op = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_n = ACCESS;
          owner_n = pick;
          load_op = 1'b1;
        end
      end
      ACCESS: state_n = RESP;
      RESP: begin
        // Only the other core may follow back-to-back; the owner's still-held
        // request is the one just being completed.
        if (owner ? req0 : req1) begin
          state_n = ACCESS;
          owner_n = ~owner;
          load_op = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign cpu0_stall = req0 & ~((state == RESP) & ~owner);
  assign cpu1_stall = req1 & ~((state == RESP) & owner);
  assign conflict   = req0 & req1 & (cpu0_stall | cpu1_stall);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_owner   <= 1'b1;
      op_addr      <= '0;
      op_wdata     <= '0;
      op_write     <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      conflict_cnt <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      if (load_op) begin
        op_addr  <= owner_n ? cpu1_addr[LDataMem-1:0] : cpu0_addr[LDataMem-1:0];
        op_wdata <= owner_n ? cpu1_wdata : cpu0_wdata;
        op_write <= owner_n ? cpu1_write : cpu0_write;
      end
      if (state == RESP) begin
        last_owner <= owner;
        if (!op_write) begin
          if (owner) rdata1_q <= mem_rdata;
          else       rdata0_q <= mem_rdata;
        end
      end
      if (conflict && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

  assign mem_we    = (state == ACCESS) & op_write;
  assign mem_re    = (state == ACCESS) & ~op_write;
  assign mem_addr  = (state == ACCESS) ? op_addr : '0;
  assign mem_wdata = (state == ACCESS) ? op_wdata : '0;

  // RAM data arrives during RESP, so it is forwarded straight through then.
  assign cpu0_rdata = ((state == RESP) & ~owner & ~op_write) ? mem_rdata : rdata0_q;
  assign cpu1_rdata = ((state == RESP) & owner & ~op_write) ? mem_rdata : rdata1_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter with a behavioural single-port RAM.
module tb_shared_mem_arbiter;
  import nrisc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu0_addr = '0, cpu0_wdata = '0, cpu1_addr = '0, cpu1_wdata = '0;
  logic        cpu0_load = 1'b0, cpu0_write = 1'b0, cpu1_load = 1'b0, cpu1_write = 1'b0;
  logic [15:0] cpu0_rdata, cpu1_rdata;
  logic        cpu0_stall, cpu1_stall;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
  logic [15:0] conflict_cnt;
  state_t      dbg_state;

  logic [15:0] ram [256];
  logic [0:0]  exp_q [$];
  int          checks = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  shared_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu0_addr(cpu0_addr), .cpu0_wdata(cpu0_wdata), .cpu0_load(cpu0_load),
    .cpu0_write(cpu0_write), .cpu0_rdata(cpu0_rdata), .cpu0_stall(cpu0_stall),
    .cpu1_addr(cpu1_addr), .cpu1_wdata(cpu1_wdata), .cpu1_load(cpu1_load),
    .cpu1_write(cpu1_write), .cpu1_rdata(cpu1_rdata), .cpu1_stall(cpu1_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt), .dbg_state(dbg_state)
  );

  // Synchronous RAM: read data one cycle after mem_re; fixed words reloaded in reset.
  always @(posedge clk) begin
    if (rst) begin
      ram[8'h01] <= 16'hA001;
      ram[8'h02] <= 16'hB002;
      ram[8'h05] <= 16'hBEEF;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic do_reset();
    rst = 1'b1;
    cpu0_load = 0; cpu0_write = 0; cpu1_load = 0; cpu1_write = 0;
    cpu0_addr = '0; cpu1_addr = '0; cpu0_wdata = '0; cpu1_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dbg_state !== IDLE) begin fails++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
    checks++; if ({mem_we, mem_re} !== 2'b00) begin fails++; $display("FAIL reset_we_re: got %b expected 00", {mem_we, mem_re}); end
    checks++; if (mem_addr !== 8'h00 || mem_wdata !== 16'h0000) begin fails++; $display("FAIL reset_mem_bus: got %h/%h expected 00/0000", mem_addr, mem_wdata); end
    checks++; if (cpu0_rdata !== 16'h0 || cpu1_rdata !== 16'h0) begin fails++; $display("FAIL reset_rdata: got %h/%h expected 0000/0000", cpu0_rdata, cpu1_rdata); end
    checks++; if (conflict_cnt !== 16'h0) begin fails++; $display("FAIL reset_cnt: got %h expected 0000", conflict_cnt); end
    checks++; if ({cpu0_stall, cpu1_stall} !== 2'b00) begin fails++; $display("FAIL reset_stall: got %b expected 00", {cpu0_stall, cpu1_stall}); end
  endtask

  task automatic test_single_load();
    cpu0_addr = 16'h0105; cpu0_load = 1'b1;
    #1;
    checks++; if (cpu0_stall !== 1'b1) begin fails++; $display("FAIL load_stall_n: got %b expected 1", cpu0_stall); end
    @(posedge clk); #1;
    checks++; if (mem_re !== 1'b1 || mem_we !== 1'b0) begin fails++; $display("FAIL load_re_n1: got re=%b we=%b expected re=1 we=0", mem_re, mem_we); end
    checks++; if (mem_addr !== 8'h05) begin fails++; $display("FAIL load_addr_n1: got %h expected 05", mem_addr); end
    checks++; if (cpu0_stall !== 1'b1) begin fails++; $display("FAIL load_stall_n1: got %b expected 1", cpu0_stall); end
    @(posedge clk); #1;
    checks++; if (cpu0_stall !== 1'b0) begin fails++; $display("FAIL load_stall_n2: got %b expected 0", cpu0_stall); end
    checks++; if (cpu0_rdata !== 16'hBEEF) begin fails++; $display("FAIL load_rdata_n2: got %h expected beef", cpu0_rdata); end
    cpu0_load = 1'b0;
    @(posedge clk); #1;
    checks++; if (cpu0_rdata !== 16'hBEEF) begin fails++; $display("FAIL load_rdata_hold: got %h expected beef", cpu0_rdata); end
    checks++; if (dbg_state !== IDLE || mem_re !== 1'b0) begin fails++; $display("FAIL load_idle: got state=%0d re=%b expected state=0 re=0", dbg_state, mem_re); end
  endtask

  task automatic test_write_tie();
    do_reset();
    cpu0_addr = 16'h0110; cpu0_wdata = 16'h1111; cpu0_write = 1'b1;
    cpu1_addr = 16'h0110; cpu1_wdata = 16'h2222; cpu1_write = 1'b1;
    #1;
    checks++; if ({cpu0_stall, cpu1_stall} !== 2'b11) begin fails++; $display("FAIL tie_stall_n: got %b expected 11", {cpu0_stall, cpu1_stall}); end
    @(posedge clk); #1;
    checks++; if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 8'h10 || mem_wdata !== 16'h1111) begin fails++; $display("FAIL tie_core0_access: got we=%b re=%b addr=%h wdata=%h expected 1 0 10 1111", mem_we, mem_re, mem_addr, mem_wdata); end
    checks++; if (conflict_cnt !== 16'd1) begin fails++; $display("FAIL tie_cnt_n1: got %0d expected 1", conflict_cnt); end
    @(posedge clk); #1;
    checks++; if ({cpu0_stall, cpu1_stall} !== 2'b01) begin fails++; $display("FAIL tie_stall_n2: got %b expected 01", {cpu0_stall, cpu1_stall}); end
    checks++; if (ram[8'h10] !== 16'h1111) begin fails++; $display("FAIL tie_ram_core0: got %h expected 1111", ram[8'h10]); end
    checks++; if (conflict_cnt !== 16'd2) begin fails++; $display("FAIL tie_cnt_n2: got %0d expected 2", conflict_cnt); end
    cpu0_write = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_we !== 1'b1 || mem_wdata !== 16'h2222 || cpu1_stall !== 1'b1) begin fails++; $display("FAIL tie_core1_access_n3: got we=%b wdata=%h stall1=%b expected 1 2222 1", mem_we, mem_wdata, cpu1_stall); end
    @(posedge clk); #1;
    checks++; if (cpu1_stall !== 1'b0) begin fails++; $display("FAIL tie_stall1_n4: got %b expected 0", cpu1_stall); end
    cpu1_write = 1'b0;
    @(posedge clk); #1;
    checks++; if (ram[8'h10] !== 16'h2222) begin fails++; $display("FAIL tie_ram_final: got %h expected 2222", ram[8'h10]); end
    checks++; if (conflict_cnt !== 16'd2) begin fails++; $display("FAIL tie_cnt_final: got %0d expected 2", conflict_cnt); end
  endtask

  task automatic test_round_robin();
    int run0 = 0, run1 = 0, max0 = 0, max1 = 0, grants = 0;
    do_reset();
    exp_q = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    cpu0_addr = 16'h0101; cpu0_load = 1'b1;
    cpu1_addr = 16'h0102; cpu1_load = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) begin @(posedge clk); end
      #1;
      if (cpu0_stall) begin run0++; if (run0 > max0) max0 = run0; end else run0 = 0;
      if (cpu1_stall) begin run1++; if (run1 > max1) max1 = run1; end else run1 = 0;
      if (!cpu0_stall || !cpu1_stall) begin
        logic [0:0] exp_g, got_g;
        got_g = cpu0_stall ? 1'b1 : 1'b0;
        exp_g = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        grants++;
        checks++; if (got_g !== exp_g) begin fails++; $display("FAIL rr_grant_%0d: got core%0d expected core%0d", grants, got_g, exp_g); end
        checks++; if (got_g == 1'b0 && cpu0_rdata !== 16'hA001) begin fails++; $display("FAIL rr_rdata0: got %h expected a001", cpu0_rdata); end
        checks++; if (got_g == 1'b1 && cpu1_rdata !== 16'hB002) begin fails++; $display("FAIL rr_rdata1: got %h expected b002", cpu1_rdata); end
      end
    end
    cpu0_load = 1'b0; cpu1_load = 1'b0;
    checks++; if (grants !== 6) begin fails++; $display("FAIL rr_grant_count: got %0d expected 6", grants); end
    checks++; if (max0 > 4 || max1 > 4) begin fails++; $display("FAIL rr_max_wait: got %0d/%0d expected <=4", max0, max1); end
    @(posedge clk); #1;
    checks++; if (dbg_state !== IDLE) begin fails++; $display("FAIL rr_idle: got %0d expected %0d", dbg_state, IDLE); end
  endtask

  task automatic test_local();
    do_reset();
    cpu1_addr = 16'h0042; cpu1_load = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (cpu1_stall !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL local_cycle%0d: got stall=%b re=%b we=%b expected 0 0 0", c, cpu1_stall, mem_re, mem_we); end
      @(posedge clk);
      if (c == 1) begin cpu1_load = 1'b0; cpu1_write = 1'b1; end
    end
    #1;
    checks++; if (conflict_cnt !== 16'd0 || dbg_state !== IDLE) begin fails++; $display("FAIL local_cnt_state: got cnt=%0d state=%0d expected 0 0", conflict_cnt, dbg_state); end
    cpu1_write = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    cpu0_addr = 16'h0120; cpu0_wdata = 16'h5555; cpu0_write = 1'b1;
    cpu1_addr = 16'h0120; cpu1_wdata = 16'h6666; cpu1_write = 1'b1;
    @(posedge clk); #1;
    checks++; if (dbg_state !== ACCESS || mem_we !== 1'b1 || conflict_cnt !== 16'd1) begin fails++; $display("FAIL rstmid_pre: got state=%0d we=%b cnt=%0d expected 1 1 1", dbg_state, mem_we, conflict_cnt); end
    rst = 1'b1; cpu0_write = 1'b0; cpu1_write = 1'b0;
    @(posedge clk); #1;
    checks++; if ({mem_we, mem_re} !== 2'b00 || mem_addr !== 8'h00 || mem_wdata !== 16'h0000) begin fails++; $display("FAIL rstmid_mem: got we=%b re=%b addr=%h wdata=%h expected all 0", mem_we, mem_re, mem_addr, mem_wdata); end
    checks++; if (dbg_state !== IDLE || conflict_cnt !== 16'd0) begin fails++; $display("FAIL rstmid_state_cnt: got state=%0d cnt=%0d expected 0 0", dbg_state, conflict_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    cpu0_addr = 16'h0101; cpu0_load = 1'b1;
    cpu1_addr = 16'h0102; cpu1_load = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    checks++; if (conflict_cnt !== 16'd100) begin fails++; $display("FAIL sat_cnt_100: got %0d expected 100", conflict_cnt); end
    repeat (65435) @(posedge clk);
    #1;
    checks++; if (conflict_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_cnt_max: got %h expected ffff", conflict_cnt); end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (conflict_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_cnt_hold: got %h expected ffff", conflict_cnt); end
    cpu0_load = 1'b0; cpu1_load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_write_tie();
    test_round_robin();
    test_local();
    test_reset_mid_access();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
